// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction encoding and fetch-stage types
//
// Purpose : instruction word layout, flag/opcode encodings and fetch FSM states
//           used by instr_fetch_unit and its helpers.
// Contents: instr_t {flag[2],opcode[5],rd[5],rs1[5],rs2[5],pc[5],imm[32]} (59 bits)
//           FLAG_REG/FLAG_IMM, OP_ADD/OP_MUL, ifu_state_e, is_legal()
package cpu_pkg;

   localparam logic [1:0] FLAG_REG = 2'b00;
   localparam logic [1:0] FLAG_IMM = 2'b01;
   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_MUL   = 5'd1;

   typedef struct packed {
      logic [1:0]  flag;
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  pc;
      logic [31:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      IFU_IDLE  = 2'd0,
      IFU_FETCH = 2'd1,
      IFU_DRAIN = 2'd2,
      IFU_DONE  = 2'd3
   } ifu_state_e;

   // Only register/immediate forms of ADD and MUL are executable.
   function automatic logic is_legal(input instr_t w);
      return ((w.flag == FLAG_REG) || (w.flag == FLAG_IMM)) &&
             ((w.opcode == OP_ADD) || (w.opcode == OP_MUL));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush
//
// Purpose: small first-word-fall-through FIFO holding fetched words.
// Ports  : clk, rst (async, active-high), flush (clears contents),
//          push/din (write), pop (read, advances head), dout (head word),
//          count (occupancy), full, empty.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             wr_ok;
   logic             rd_ok;

   // A full FIFO may still accept a write when the head leaves in the same cycle.
   assign wr_ok = push && (!full || pop);
   assign rd_ok = pop && !empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with prefetch FIFO and redirect
//
// Purpose: walks the PC through a sync-read imem, buffers words in fetch_fifo and
//          presents them on a valid/ready output register.
// Ports  : clk, rst (async, active-high); start/prog_len launch a program;
//          redirect/redirect_pc flush and reload the PC; imem_en/imem_addr/
//          imem_rdata memory port; out_valid/out_ready handshake with out_instr,
//          decoded slices (out_flag..out_imm) and out_pc; busy; done pulse.
// Option : IFU_ILLEGAL_CHECK_EN drops non ADD/MUL words and reports them on
//          illegal_o/illegal_pc_o.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W       = 5,
   parameter int INSTR_W    = 59,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [PC_W-1:0]    prog_len,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               imem_en,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [1:0]         out_flag,
   output logic [4:0]         out_opcode,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [31:0]        out_imm,
   output logic [PC_W-1:0]    out_pc,
`ifdef IFU_ILLEGAL_CHECK_EN
   output logic               illegal_o,
   output logic [PC_W-1:0]    illegal_pc_o,
`endif
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = INSTR_W + PC_W;

   ifu_state_e          state;
   logic [PC_W-1:0]     pc;
   logic [PC_W-1:0]     last_pc;
   logic                epoch;
   logic                inflight;
   logic                inflight_epoch;
   logic [PC_W-1:0]     inflight_pc;

   logic [CW-1:0]       fifo_count;
   logic                fifo_full;
   logic                fifo_empty;
   logic [EW-1:0]       fifo_dout;
   logic                fifo_push;
   logic                fifo_pop;

   logic                redir;
   logic                resp_ok;
   logic                load;
   logic                take;
   logic                src_valid;
   logic [INSTR_W-1:0]  src_instr;
   logic [PC_W-1:0]     src_pc;
   logic                src_legal;
   logic [CW:0]         credit_used;

   assign out_flag   = out_instr[58:57];
   assign out_opcode = out_instr[56:52];
   assign out_rd     = out_instr[51:47];
   assign out_rs1    = out_instr[46:42];
   assign out_rs2    = out_instr[41:37];
   assign out_imm    = out_instr[31:0];

   assign busy  = (state == IFU_FETCH) || (state == IFU_DRAIN);
   assign redir = redirect && (state != IFU_IDLE);

   // A response is kept only if no redirect happened since it was issued.
   assign resp_ok = inflight && (inflight_epoch == epoch);

   // With the FIFO empty the returning word bypasses it straight into the
   // output register, which gives the 2-cycle start-to-valid latency.
   assign src_valid = !fifo_empty || resp_ok;
   assign src_instr = fifo_empty ? imem_rdata  : fifo_dout[EW-1:PC_W];
   assign src_pc    = fifo_empty ? inflight_pc : fifo_dout[PC_W-1:0];
   assign load      = !out_valid || out_ready;
   assign take      = load && src_valid && !redir;
   assign fifo_pop  = take && !fifo_empty;
   assign fifo_push = resp_ok && !(take && fifo_empty);

`ifdef IFU_ILLEGAL_CHECK_EN
   assign src_legal = is_legal(src_instr);
`else
   assign src_legal = 1'b1;
`endif

   // Words already buffered plus the one in flight, minus the head leaving now;
   // issuing only below FIFO_DEPTH means every response has a slot.
   assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(fifo_pop);
   assign imem_en     = (state == IFU_FETCH) && !redir && !fifo_full &&
                        (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_addr   = pc;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redir),
      .push  (fifo_push),
      .din   ({imem_rdata, inflight_pc}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IFU_IDLE;
         pc             <= '0;
         last_pc        <= '0;
         epoch          <= 1'b0;
         inflight       <= 1'b0;
         inflight_epoch <= 1'b0;
         inflight_pc    <= '0;
         out_valid      <= 1'b0;
         out_instr      <= '0;
         out_pc         <= '0;
         done           <= 1'b0;
`ifdef IFU_ILLEGAL_CHECK_EN
         illegal_o      <= 1'b0;
         illegal_pc_o   <= '0;
`endif
      end else begin
         done <= 1'b0;
`ifdef IFU_ILLEGAL_CHECK_EN
         illegal_o <= 1'b0;
`endif
         inflight <= imem_en;
         if (imem_en) begin
            inflight_epoch <= epoch;
            inflight_pc    <= pc;
            pc             <= pc + PC_W'(1);
         end

         if (redir) begin
            out_valid <= 1'b0;
         end else if (take) begin
            if (src_legal) begin
               out_valid <= 1'b1;
               out_instr <= src_instr;
               out_pc    <= src_pc;
            end else begin
               out_valid <= 1'b0;
`ifdef IFU_ILLEGAL_CHECK_EN
               illegal_o    <= 1'b1;
               illegal_pc_o <= src_pc;
`endif
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (redir) begin
            epoch <= ~epoch;
            pc    <= redirect_pc;
            state <= IFU_FETCH;
         end else begin
            unique case (state)
               IFU_IDLE, IFU_DONE: begin
                  if (start) begin
                     state   <= IFU_FETCH;
                     pc      <= '0;
                     last_pc <= prog_len;
                  end
               end
               IFU_FETCH: begin
                  if (imem_en && (pc == last_pc)) begin
                     state <= IFU_DRAIN;
                  end
               end
               IFU_DRAIN: begin
                  // Nothing left upstream; finish once the output word is gone.
                  if (fifo_empty && !inflight && (!out_valid || out_ready)) begin
                     state <= IFU_DONE;
                     done  <= 1'b1;
                  end
               end
               default: state <= IFU_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard testbench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  prog_len;
   logic        redirect;
   logic [4:0]  redirect_pc;
   logic        imem_en;
   logic [4:0]  imem_addr;
   logic [58:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [58:0] out_instr;
   logic [1:0]  out_flag;
   logic [4:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [31:0] out_imm;
   logic [4:0]  out_pc;
   logic        busy;
   logic        done;
`ifdef IFU_ILLEGAL_CHECK_EN
   logic        illegal_o;
   logic [4:0]  illegal_pc_o;
`endif

   logic [58:0] mem [32];
   logic [63:0] expq [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          done_cnt = 0;
   int          issue_cnt = 0;
   int          illegal_cnt = 0;
   logic [4:0]  illegal_pc_last = '0;
   logic        prev_hold = 1'b0;
   logic [4:0]  hold_pc = '0;
   logic [58:0] hold_instr = '0;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .prog_len    (prog_len),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_flag    (out_flag),
      .out_opcode  (out_opcode),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_imm     (out_imm),
      .out_pc      (out_pc),
`ifdef IFU_ILLEGAL_CHECK_EN
      .illegal_o   (illegal_o),
      .illegal_pc_o(illegal_pc_o),
`endif
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [58:0] mk(input logic [1:0] f, input logic [4:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] fp,
                                      input logic [31:0] imm);
      return {f, op, rd, rs1, rs2, fp, imm};
   endfunction

   // Monitor: checks every accepted word against the scoreboard head.
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst) begin
         if (out_valid) begin
            if (prev_hold) begin
               chk("hold_pc", 64'(out_pc), 64'(hold_pc));
               chk("hold_instr", 64'(out_instr), 64'(hold_instr));
            end
            if (out_ready) begin
               if (expq.size() == 0) begin
                  chk("unexpected_word_pc", 64'(out_pc), 64'h3f);
               end else begin
                  e = expq.pop_front();
                  chk("out_pc", 64'(out_pc), 64'(e[63:59]));
                  chk("out_instr", 64'(out_instr), 64'(e[58:0]));
                  chk("out_opcode", 64'(out_opcode), 64'(e[56:52]));
                  chk("out_imm", 64'(out_imm), 64'(e[31:0]));
               end
            end
         end
         prev_hold  = out_valid && !out_ready;
         hold_pc    = out_pc;
         hold_instr = out_instr;
         if (done) done_cnt++;
         if (imem_en) issue_cnt++;
`ifdef IFU_ILLEGAL_CHECK_EN
         if (illegal_o) begin
            illegal_cnt++;
            illegal_pc_last = illegal_pc_o;
         end
`endif
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic load_basic();
      for (int i = 0; i < 32; i++)
         mem[i] = mk(2'(i % 2), 5'((i / 2) % 2), 5'(i), 5'(i + 1), 5'(i + 2), 5'(i),
                     32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);
      mem[0] = mk(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0000_0000);
      mem[1] = mk(2'b01, 5'd0, 5'd4, 5'd5, 5'd0, 5'd1, 32'h0000_0010);
      mem[2] = mk(2'b00, 5'd1, 5'd6, 5'd7, 5'd8, 5'd2, 32'h0000_0000);
      mem[3] = mk(2'b01, 5'd1, 5'd9, 5'd10, 5'd0, 5'd3, 32'hFFFF_FFF0);
   endtask

   task automatic push_exp(input int a, input int b);
      for (int p = a; p <= b; p++) expq.push_back({5'(p), mem[p]});
   endtask

   // Returns one time unit after the edge that samples start.
   task automatic do_start(input logic [4:0] len);
      @(posedge clk); #1;
      prog_len = len;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget, input logic rand_rdy);
      int n = 0;
      while ((busy || expq.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk({nm, "_finish"}, 64'(n < budget), 64'd1);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; prog_len = '0; redirect = 1'b0;
      redirect_pc = '0; out_ready = 1'b0; imem_rdata = '0;
      load_basic();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_imem_en", 64'(imem_en), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      rst = 1'b0;

      // 1: four instructions at full rate
      out_ready = 1'b1; done_cnt = 0;
      push_exp(0, 3);
      do_start(5'd3);
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         chk("t1_valid", 64'(out_valid), 64'd1);
         chk("t1_pc_seq", 64'(out_pc), 64'(k));
         @(posedge clk); #1;
      end
      wait_idle("t1", 50, 1'b0);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      chk("t1_busy", 64'(busy), 64'd0);

      // 2: backpressure stops issue at four, nothing lost
      out_ready = 1'b0; done_cnt = 0; issue_cnt = 0;
      push_exp(0, 3);
      do_start(5'd3);
      repeat (10) @(posedge clk);
      #1;
      chk("t2_issues", 64'(issue_cnt), 64'd4);
      chk("t2_held_valid", 64'(out_valid), 64'd1);
      chk("t2_held_pc", 64'(out_pc), 64'd0);
      out_ready = 1'b1;
      wait_idle("t2", 50, 1'b0);
      chk("t2_done_cnt", 64'(done_cnt), 64'd1);

      // 3: redirect to pc 2 while pc 0 is held and pc 1 is in flight
      out_ready = 1'b0; done_cnt = 0;
      push_exp(0, 3);
      do_start(5'd3);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("t3_first_valid", 64'(n < 20), 64'd1);
      redirect_pc = 5'd2; redirect = 1'b1;
      @(posedge clk); #1;
      redirect = 1'b0;
      expq.delete();
      push_exp(2, 3);
      chk("t3_flush_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      wait_idle("t3", 50, 1'b0);
      chk("t3_done_cnt", 64'(done_cnt), 64'd1);

      // 4: asynchronous reset mid-fetch, then restart from pc 0
      out_ready = 1'b1; done_cnt = 0;
      push_exp(0, 10);
      do_start(5'd10);
      repeat (2) @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("t4_rst_valid", 64'(out_valid), 64'd0);
      chk("t4_rst_busy", 64'(busy), 64'd0);
      chk("t4_rst_imem_en", 64'(imem_en), 64'd0);
      expq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_no_done", 64'(done_cnt), 64'd0);
      push_exp(0, 3);
      do_start(5'd3);
      wait_idle("t4", 50, 1'b0);
      chk("t4_done_cnt", 64'(done_cnt), 64'd1);

      // 5: full 32-word program with random backpressure
      done_cnt = 0; issue_cnt = 0;
      push_exp(0, 31);
      do_start(5'd31);
      wait_idle("t5", 3000, 1'b1);
      chk("t5_done_cnt", 64'(done_cnt), 64'd1);
      chk("t5_issues", 64'(issue_cnt), 64'd32);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_wrap_issue", 64'(issue_cnt), 64'd32);

`ifdef IFU_ILLEGAL_CHECK_EN
      // 6: illegal flag at pc 1 is dropped and reported
      load_basic();
      mem[1][58:57] = 2'b11;
      done_cnt = 0; illegal_cnt = 0;
      push_exp(0, 0);
      push_exp(2, 3);
      do_start(5'd3);
      wait_idle("t6", 50, 1'b0);
      chk("t6_illegal_cnt", 64'(illegal_cnt), 64'd1);
      chk("t6_illegal_pc", 64'(illegal_pc_last), 64'd1);
      chk("t6_done_cnt", 64'(done_cnt), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
